vid_rd_sched: RTL
=================

# vid_rd_sched

Read-side scheduler for the HDMI output frame buffer. Each frame it selects the most recently completed frame in DDR, flushes the line FIFO and keeps that FIFO topped up. It does this by issuing burst read requests, one at a time, to the DDR read port. It sits between the video timing generator (which supplies `vs` and `de_read`) and the DDR read arbiter/line FIFO. It also counts display underruns.

## Interface
- `H_ACTIVE`, 1920: active pixels per line
- `V_ACTIVE`, 1080: active lines per frame
- `BYTES_PER_PIX`, 2: bytes per pixel in DDR
- `BEAT_BYTES`, 32: bytes per DDR read beat
- `BURST_LEN`, 64: maximum beats per request
- `FIFO_DEPTH`, 512: line FIFO depth in beats
- `NUM_FRAMES`, 3: frame buffers in DDR
- `FRAME_BASE`, 0: byte address of frame 0
- `ADDR_W`, 28: byte address width
- `VS_POL`, 1: active level of `vs`
- Derived: `LINE_BEATS = H_ACTIVE*BYTES_PER_PIX/BEAT_BYTES` (must be an exact integer); `FRAME_BEATS = LINE_BEATS*V_ACTIVE`; `FRAME_BYTES = FRAME_BEATS*BEAT_BYTES`

Ports:
- `clk`  in  1  pixel/system clock; single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `vs`  in  1  vertical sync from the timing generator
- `de_read`  in  1  FIFO read strobe from the timing generator
- `fifo_wr_cnt`  in  $clog2(FIFO_DEPTH)+1  line FIFO fill level, in beats
- `fifo_empty`  in  1  line FIFO empty
- `fifo_flush`  out  1  synchronous FIFO clear
- `wr_frame_idx`  in  2  index of the last frame the writer completed
- `rd_frame_idx`  out  2  frame currently being read
- `rd_req`  out  1  burst request
- `rd_addr`  out  ADDR_W  burst byte address
- `rd_len`  out  8  burst length in beats (1..BURST_LEN)
- `rd_ack`  in  1  request accepted
- `rd_done`  in  1  last beat of the burst written into the FIFO
- `underrun_cnt`  out  16  saturating count of underruns
- `busy`  out  1  frame fetch in progress

## Operation
- **Frame start:** a frame start is the cycle `vs` changes from `!VS_POL` to `VS_POL`, detected with a registered `vs`.
- **States:**
  - IDLE: wait for a frame start.
  - FLUSH: hold `fifo_flush` high for 4 cycles; latch `rd_frame_idx <= wr_frame_idx`; set `rd_addr <= FRAME_BASE + rd_frame_idx*FRAME_BYTES`; set `remain <= FRAME_BEATS`.
  - FILL: if `remain == 0`, go to DONE. Else if `FIFO_DEPTH - fifo_wr_cnt >= min(BURST_LEN, remain)`, load `rd_len` with that value and go to REQ.
  - REQ: hold `rd_req` high. On `rd_ack`, drop `rd_req` and go to WAIT.
  - WAIT: on `rd_done`, update `rd_addr += rd_len*BEAT_BYTES` and `remain -= rd_len`, then go to SETTLE.
  - SETTLE: 2 cycles, covering FIFO level latency, then go to FILL.
  - DONE: wait for a frame start, then go to FLUSH.
- **Frame start mid-fetch (FILL/SETTLE):** go directly to FLUSH.
- **Frame start mid-fetch (REQ/WAIT):** set `restart_pend`. The current handshake completes through `rd_done`; it is never abandoned. Then go to FLUSH instead of SETTLE.
- **Underrun:** any cycle with `de_read && fifo_empty` increments `underrun_cnt`. The count saturates at 16'hFFFF and is cleared only by reset.
- **Writer index:** `wr_frame_idx >= NUM_FRAMES` is treated as 0.
- **`busy`:** high in FLUSH, FILL, REQ, WAIT and SETTLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `restart_pend` 0.
- **Outputs:** all registered. `rd_addr`/`rd_len` are stable from `rd_req` rise until the cycle after `rd_ack`.
- **Handshake:** `rd_req` falls the cycle after `rd_ack` is sampled high. `rd_ack` in the same cycle `rd_req` rises is legal. At most 1 outstanding burst.
- **Latency:** first `rd_req` rises 6 cycles after the frame-start cycle (1 edge detect + 4 FLUSH + 1 FILL).
- **Arithmetic:** address arithmetic is unsigned modulo 2^ADDR_W. `remain` is at least $clog2(FRAME_BEATS)+1 bits.
- **Reset mid-burst:** immediate return to IDLE. The arbiter is reset by the same `rst`.

## Test plan
Bench parameters: `H_ACTIVE=64`, `V_ACTIVE=5`, `BYTES_PER_PIX=2`, `BEAT_BYTES=32`, `BURST_LEN=8`, `FIFO_DEPTH=16`; this gives 20 beats and 640 bytes per frame.

1. **Normal frame:** `wr_frame_idx=2`, FIFO model drains instantly, `vs` edge. Expect `fifo_flush` high for 4 cycles, `rd_frame_idx=2`, then requests (addr, len) = (1280,8), (1536,8), (1792,4), then DONE with `busy=0`.
2. **Backpressure:** `fifo_wr_cnt` held at 10. Expect no `rd_req` (free space 6 < 8). Release to 8: `rd_req` rises within 2 cycles.
3. **Delayed ack:** `rd_ack` delayed 20 cycles. Expect `rd_req`, `rd_addr`, `rd_len` stable for all 20 cycles; `rd_req` low the cycle after ack.
4. **Frame start during WAIT:** `vs` edge during WAIT, `rd_done` 5 cycles later. Expect no new request before `rd_done`, then FLUSH and a request at the new frame base.
5. **Underrun counting:** `de_read=1`, `fifo_empty=1` for 3 cycles. Expect `underrun_cnt=3`. Force 70000 cycles: expect the count to hold at 65535.
6. **Reset in REQ:** assert `rst` while in REQ. Expect `rd_req=0` and `fifo_flush=0` asynchronously; after release, no request until the next `vs` edge.

Source files
------------

// File: rtl/vid_rd_sched.sv
// vid_rd_sched: read-side scheduler for the HDMI frame buffer.
// Selects the newest frame on vsync, flushes the line FIFO, then streams it in bursts.
module vid_rd_sched #(
  parameter int H_ACTIVE      = 1920,
  parameter int V_ACTIVE      = 1080,
  parameter int BYTES_PER_PIX = 2,
  parameter int BEAT_BYTES    = 32,
  parameter int BURST_LEN     = 64,
  parameter int FIFO_DEPTH    = 512,
  parameter int NUM_FRAMES    = 3,
  parameter int FRAME_BASE    = 0,
  parameter int ADDR_W        = 28,
  parameter bit VS_POL        = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vs,
  input  logic                        de_read,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_wr_cnt,
  input  logic                        fifo_empty,
  output logic                        fifo_flush,
  input  logic [1:0]                  wr_frame_idx,
  output logic [1:0]                  rd_frame_idx,
  output logic                        rd_req,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [7:0]                  rd_len,
  input  logic                        rd_ack,
  input  logic                        rd_done,
  output logic [15:0]                 underrun_cnt,
  output logic                        busy
);

  localparam int LINE_BEATS  = H_ACTIVE * BYTES_PER_PIX / BEAT_BYTES;
  localparam int FRAME_BEATS = LINE_BEATS * V_ACTIVE;
  localparam int FRAME_BYTES = FRAME_BEATS * BEAT_BYTES;
  localparam int REM_W       = $clog2(FRAME_BEATS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_REQ,
    S_WAIT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic              restart_pend;
  logic [REM_W-1:0]  remain;

  logic              vs_q;
  logic              fs;

  logic [1:0]        idx_s;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] step;
  logic [31:0]       free_w;
  logic [31:0]       need_w;
  logic              go_flush;

  // Register vs and emit a one-cycle pulse on its inactive-to-active edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q <= VS_POL;
      fs   <= 1'b0;
    end else begin
      vs_q <= vs;
      fs   <= (vs == VS_POL) && (vs_q != VS_POL);
    end
  end

  // Frame base, burst step and FIFO room for the current decision
  always_comb begin
    idx_s = wr_frame_idx;
    if (32'(wr_frame_idx) >= 32'(NUM_FRAMES)) begin
      idx_s = 2'd0;
    end
    base = ADDR_W'(FRAME_BASE)
         + ADDR_W'(idx_s) * ADDR_W'(FRAME_BYTES);
    step = ADDR_W'(rd_len) * ADDR_W'(BEAT_BYTES);
    free_w = 32'd0;
    if (32'(fifo_wr_cnt) < 32'(FIFO_DEPTH)) begin
      free_w = 32'(FIFO_DEPTH) - 32'(fifo_wr_cnt);
    end
    need_w = 32'(remain);
    if (32'(remain) > 32'(BURST_LEN)) begin
      need_w = 32'(BURST_LEN);
    end
  end

  // Decide when to (re)start a frame; an accepted burst is never abandoned
  always_comb begin
    go_flush = 1'b0;
    case (state)
      S_REQ:   go_flush = 1'b0;
      S_WAIT:  go_flush = rd_done && (restart_pend || fs);
      default: go_flush = fs;
    endcase
  end

  // Main sequencer: flush, then one burst at a time until the frame is fetched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 2'd0;
      restart_pend <= 1'b0;
      remain       <= '0;
      fifo_flush   <= 1'b0;
      rd_frame_idx <= 2'd0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      rd_len       <= 8'd0;
      busy         <= 1'b0;
    end else if (go_flush) begin
      state        <= S_FLUSH;
      cnt          <= 2'd0;
      restart_pend <= 1'b0;
      remain       <= REM_W'(FRAME_BEATS);
      fifo_flush   <= 1'b1;
      rd_frame_idx <= idx_s;
      rd_req       <= 1'b0;
      rd_addr      <= base;
      busy         <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
        end
        S_FLUSH: begin
          if (cnt == 2'd3) begin
            fifo_flush <= 1'b0;
            state      <= S_FILL;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_FILL: begin
          if (remain == '0) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else if (free_w >= need_w) begin
            rd_len <= need_w[7:0];
            rd_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (fs) begin
            restart_pend <= 1'b1;
          end
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rd_done) begin
            rd_addr <= rd_addr + step;
            remain  <= remain - REM_W'(rd_len);
            cnt     <= 2'd0;
            state   <= S_SETTLE;
          end else if (fs) begin
            restart_pend <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == 2'd1) begin
            state <= S_FILL;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating count of display reads that found the FIFO empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= 16'd0;
    end else if (de_read && fifo_empty
                 && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule
